// File: rtl/causal_template_fetch_pkg.sv
// causal_template_fetch_pkg: shared defaults and T.87 edge-rule constants for the causal template fetch.
package causal_template_fetch_pkg;
  localparam int def_pixel_length = 8;
  localparam int def_img_width = 16;
  localparam int def_img_height = 16;
  localparam int edge_fill = 0;
  function automatic int at_least_one(input int n);
    return n > 0 ? n : 1;
  endfunction
endpackage

// File: rtl/causal_template_fetch_line_buffer.sv
// causal_template_fetch_line_buffer: one row of samples, two async read ports, one sync write port.
module causal_template_fetch_line_buffer #(
  parameter int depth = 16,
  parameter int width = 8,
  parameter int aw = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [aw-1:0]    waddr,
  input  logic [width-1:0] wdata,
  input  logic [aw-1:0]    raddr0,
  output logic [width-1:0] rdata0,
  input  logic [aw-1:0]    raddr1,
  output logic [width-1:0] rdata1
);
  logic [width-1:0] mem [depth];
  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
endmodule

// File: rtl/causal_template_fetch.sv
// causal_template_fetch: raster pixel stream to x plus causal neighbours a/b/c/d with T.87 edge rules.
module causal_template_fetch
  import causal_template_fetch_pkg::*;
#(
  parameter int pixel_length = def_pixel_length,
  parameter int img_width = def_img_width,
  parameter int img_height = def_img_height,
  parameter int col_length = $clog2(img_width),
  parameter int row_length = $clog2(img_height)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [pixel_length-1:0] pixel_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [pixel_length-1:0] x,
  output logic [pixel_length-1:0] a,
  output logic [pixel_length-1:0] b,
  output logic [pixel_length-1:0] c,
  output logic [pixel_length-1:0] d,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    first_row,
  output logic                    first_col,
  output logic                    last_col,
  output logic                    last_pixel
);
  localparam int cw = at_least_one(col_length);
  localparam int rw = at_least_one(row_length);
  localparam logic [pixel_length-1:0] fill = pixel_length'(edge_fill);
  logic [cw-1:0] col_q, col_d, rd1_addr;
  logic [rw-1:0] row_q, row_d;
  logic [pixel_length-1:0] x_q, x_d, a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic [pixel_length-1:0] prev_a_q, prev_a_d, prev_b_q, prev_b_d, row_start_c_q, row_start_c_d;
  logic [pixel_length-1:0] line_b, line_d, sel_a, sel_b, sel_c, sel_d;
  logic out_valid_q, out_valid_d, first_row_q, first_row_d, first_col_q, first_col_d;
  logic last_col_q, last_col_d, last_pixel_q, last_pixel_d;
  logic accept, at_first_row, at_first_col, at_last_col, at_last_row;
  assign in_ready = !out_valid_q || out_ready;
  assign accept = in_valid && in_ready;
  assign at_first_row = row_q == '0;
  assign at_first_col = col_q == '0;
  assign at_last_col = col_q == cw'(img_width - 1);
  assign at_last_row = row_q == rw'(img_height - 1);
  // col+1 would run past the buffer on the last column; d is taken from b there anyway
  assign rd1_addr = at_last_col ? col_q : col_q + 1'b1;
  causal_template_fetch_line_buffer #(
    .depth(img_width),
    .width(pixel_length),
    .aw(cw)
  ) u_line (
    .clk(clk),
    .we(accept),
    .waddr(col_q),
    .wdata(pixel_in),
    .raddr0(col_q),
    .rdata0(line_b),
    .raddr1(rd1_addr),
    .rdata1(line_d)
  );
  always_comb begin
    sel_b = at_first_row ? fill : line_b;
    sel_a = !at_first_col ? prev_a_q : sel_b;
    sel_c = at_first_row ? fill : at_first_col ? row_start_c_q : prev_b_q;
    sel_d = at_first_row ? fill : at_last_col ? sel_b : line_d;
    col_d = accept ? (at_last_col ? '0 : col_q + 1'b1) : col_q;
    row_d = accept && at_last_col ? (at_last_row ? '0 : row_q + 1'b1) : row_q;
    out_valid_d = accept || (out_valid_q && !out_ready);
    x_d = accept ? pixel_in : x_q;
    a_d = accept ? sel_a : a_q;
    b_d = accept ? sel_b : b_q;
    c_d = accept ? sel_c : c_q;
    d_d = accept ? sel_d : d_q;
    first_row_d = accept ? at_first_row : first_row_q;
    first_col_d = accept ? at_first_col : first_col_q;
    last_col_d = accept ? at_last_col : last_col_q;
    last_pixel_d = accept ? at_last_col && at_last_row : last_pixel_q;
    prev_a_d = accept ? pixel_in : prev_a_q;
    prev_b_d = accept ? sel_b : prev_b_q;
    row_start_c_d = accept && at_first_col ? sel_b : row_start_c_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
      out_valid_q <= 1'b0;
      x_q <= '0;
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      d_q <= '0;
      first_row_q <= 1'b0;
      first_col_q <= 1'b0;
      last_col_q <= 1'b0;
      last_pixel_q <= 1'b0;
      prev_a_q <= '0;
      prev_b_q <= '0;
      row_start_c_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      out_valid_q <= out_valid_d;
      x_q <= x_d;
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
      d_q <= d_d;
      first_row_q <= first_row_d;
      first_col_q <= first_col_d;
      last_col_q <= last_col_d;
      last_pixel_q <= last_pixel_d;
      prev_a_q <= prev_a_d;
      prev_b_q <= prev_b_d;
      row_start_c_q <= row_start_c_d;
    end
  assign out_valid = out_valid_q;
  assign x = x_q;
  assign a = a_q;
  assign b = b_q;
  assign c = c_q;
  assign d = d_q;
  assign first_row = first_row_q;
  assign first_col = first_col_q;
  assign last_col = last_col_q;
  assign last_pixel = last_pixel_q;
endmodule

// File: tb/tb_causal_template_fetch.sv
// tb_causal_template_fetch: directed stream on a 4x3 image, scoreboard of expected neighbour sets.
module tb_causal_template_fetch;
  localparam int w = 4;
  localparam int h = 3;
  typedef struct packed {
    logic [7:0] x, a, b, c, d;
    logic fr, fc, lc, lp;
    logic [7:0] col, row;
  } exp_t;
  logic clk = 0, rst;
  logic [7:0] pixel_in, x, a, b, c, d;
  logic in_valid, in_ready, out_valid, out_ready;
  logic first_row, first_col, last_col, last_pixel;
  logic [7:0] img [h][w];
  exp_t sb [$];
  int checks = 0, fails = 0;
  int pcol = 0, prow = 0;
  always #5 clk = ~clk;
  causal_template_fetch #(.pixel_length(8), .img_width(w), .img_height(h)) dut (
    .clk(clk), .rst(rst), .pixel_in(pixel_in), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .a(a), .b(b), .c(c), .d(d), .out_valid(out_valid), .out_ready(out_ready),
    .first_row(first_row), .first_col(first_col), .last_col(last_col), .last_pixel(last_pixel)
  );
  function automatic exp_t model(input int col, input int row);
    exp_t e;
    e.x = img[row][col];
    e.b = row == 0 ? 8'd0 : img[row-1][col];
    e.a = col > 0 ? img[row][col-1] : e.b;
    e.c = row == 0 ? 8'd0 : col > 0 ? img[row-1][col-1] : row >= 2 ? img[row-2][0] : 8'd0;
    e.d = row == 0 ? 8'd0 : col < w - 1 ? img[row-1][col+1] : img[row-1][col];
    e.fr = row == 0;
    e.fc = col == 0;
    e.lc = col == w - 1;
    e.lp = col == w - 1 && row == h - 1;
    e.col = 8'(col);
    e.row = 8'(row);
    return e;
  endfunction
  always @(negedge clk)
    if (out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        assert (0) else begin
          fails++;
          $error("FAIL unexpected_output got x=%0d exp none", x);
        end
      end else begin
        exp_t e;
        e = sb.pop_front();
        assert ({x, a, b, c, d, first_row, first_col, last_col, last_pixel} === {e.x, e.a, e.b, e.c, e.d, e.fr, e.fc, e.lc, e.lp}) else begin
          fails++;
          $error("FAIL px(%0d,%0d) got x=%0d a=%0d b=%0d c=%0d d=%0d f=%b%b%b%b exp x=%0d a=%0d b=%0d c=%0d d=%0d f=%b%b%b%b",
            e.col, e.row, x, a, b, c, d, first_row, first_col, last_col, last_pixel,
            e.x, e.a, e.b, e.c, e.d, e.fr, e.fc, e.lc, e.lp);
        end
      end
    end
  task automatic send();
    int n = 0;
    pixel_in = img[prow][pcol];
    in_valid = 1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (n < 50) else begin
      fails++;
      $error("FAIL send_timeout got in_ready=%b exp 1", in_ready);
    end
    sb.push_back(model(pcol, prow));
    pcol = pcol == w - 1 ? 0 : pcol + 1;
    prow = pcol == 0 ? (prow == h - 1 ? 0 : prow + 1) : prow;
    @(posedge clk);
    #1;
    in_valid = 0;
  endtask
  task automatic stall_then_send();
    out_ready = 0;
    pixel_in = img[prow][pcol];
    in_valid = 1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      assert (!in_ready && out_valid && sb.size() > 0 && x === sb[0].x) else begin
        fails++;
        $error("FAIL stall got in_ready=%b out_valid=%b x=%0d exp 0/1/%0d", in_ready, out_valid, x, sb.size() > 0 ? sb[0].x : 8'd0);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1;
    send();
  endtask
  initial begin
    for (int r = 0; r < h; r++)
      for (int k = 0; k < w; k++)
        img[r][k] = 8'(10 * (r * w + k + 1));
    rst = 1;
    in_valid = 0;
    out_ready = 1;
    pixel_in = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    assert ({out_valid, x, a, b, c, d, first_row, first_col, last_col, last_pixel, in_ready} === {1'b0, 40'd0, 4'd0, 1'b1}) else begin
      fails++;
      $error("FAIL reset got v=%b x=%0d a=%0d b=%0d c=%0d d=%0d rdy=%b exp 0,0s,1", out_valid, x, a, b, c, d, in_ready);
    end
    @(posedge clk);
    #1;
    rst = 0;
    for (int i = 0; i < 2 * w * h; i++)
      if (i == w + 2) stall_then_send();
      else send();
    for (int i = 0; i < w + 3; i++) send();
    out_ready = 0;
    rst = 1;
    sb.delete();
    pcol = 0;
    prow = 0;
    @(negedge clk);
    checks++;
    assert (out_valid === 1'b0) else begin
      fails++;
      $error("FAIL rst_mid got out_valid=%b exp 0", out_valid);
    end
    @(posedge clk);
    #1;
    rst = 0;
    out_ready = 1;
    send();
    send();
    begin
      int n = 0;
      while (sb.size() != 0 && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    @(posedge clk);
    #1;
    checks++;
    assert (sb.size() == 0) else begin
      fails++;
      $error("FAIL drain got %0d pending exp 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
